// File: rtl/rob_pkg.sv
// Shared types and width helpers for the ROB ID-allocation front end.
package rob_pkg;

   typedef enum logic [1:0] {OP_NONE, OP_ALLOC, OP_FREE} sched_op_e;
   typedef enum logic [1:0] {MODE_RUN, MODE_DRAIN, MODE_DRAINED} sched_mode_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_MAX_OUT   = 16;
   localparam int DEF_REQ_IDX_W = idx_w(DEF_NUM_REQ);
   localparam int DEF_CNT_W     = cnt_w(DEF_MAX_OUT);

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO; a push when full is dropped, a pop when empty is ignored.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign do_push = push && (count < CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/id_alloc_scheduler.sv
// Time-shares the allocator's single op slot between round-robin ALLOC requests
// and buffered FREEs, tracks outstanding IDs and supports a drain/quiesce mode.
module id_alloc_scheduler
   import rob_pkg::*;
#(
   parameter int NUM_REQ         = DEF_NUM_REQ,
   parameter int ID_WIDTH        = 16,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUT,
   parameter int FREE_DEPTH      = 4,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]    req_orig_id,
   output logic [NUM_REQ-1:0]                  req_ready,
   output logic                                rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0]          rsp_req_idx,
   output logic [ID_WIDTH-1:0]                 rsp_unique_id,
   input  logic                                free_valid,
   input  logic [ID_WIDTH-1:0]                 free_unique_id,
   output logic                                free_ready,
   output logic                                restored_valid,
   output logic [ID_WIDTH-1:0]                 restored_id_out,
   input  logic                                drain_req,
   output logic                                drain_done,
   output logic                                err_underflow,
   output logic                                alloc_req,
   output logic [ID_WIDTH-1:0]                 alloc_orig_id,
   input  logic                                alloc_gnt,
   input  logic [ID_WIDTH-1:0]                 alloc_unique_id,
   input  logic                                alloc_full,
   output logic                                free_req,
   output logic [ID_WIDTH-1:0]                 free_uid,
   input  logic [ID_WIDTH-1:0]                 alloc_restored_id
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = cnt_w(MAX_OUTSTANDING);
   localparam int STK_W = cnt_w(STARVE_LIMIT);
   localparam int FCW   = cnt_w(FREE_DEPTH);

   sched_mode_e         mode, mode_nxt;
   sched_op_e           op;
   logic [IDX_W-1:0]    rr_ptr, winner;
   logic [CNT_W-1:0]    out_cnt;
   logic [STK_W-1:0]    free_streak;
   logic [FCW-1:0]      fifo_cnt;
   logic [ID_WIDTH-1:0] fifo_head;
   logic                alloc_en, found, cand, fifo_ne, grant, push;

   // Mode FSM
   always_ff @(posedge clk) begin
      if (!rst_n) mode <= MODE_RUN;
      else        mode <= mode_nxt;
   end

   always_comb begin
      mode_nxt = mode;
      case (mode)
         MODE_RUN:     if (drain_req) mode_nxt = MODE_DRAIN;
         MODE_DRAIN:   if (out_cnt == '0 && fifo_cnt == '0) mode_nxt = MODE_DRAINED;
         MODE_DRAINED: if (!drain_req) mode_nxt = MODE_RUN;
         default:      mode_nxt = MODE_RUN;
      endcase
   end

   always_comb begin
      alloc_en   = rst_n && (mode == MODE_RUN);
      drain_done = (mode == MODE_DRAINED);
   end

   // Free queue; space freed by a pop is only visible next cycle
   assign free_ready = fifo_cnt < FCW'(FREE_DEPTH);
   assign push       = free_valid && free_ready;

   sync_fifo #(.WIDTH(ID_WIDTH), .DEPTH(FREE_DEPTH)) u_free_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (free_unique_id),
      .pop   (free_req),
      .dout  (fifo_head),
      .count (fifo_cnt)
   );

   always_comb begin : rr_arb
      int j;
      j      = 0;
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req_valid[j]) begin
            winner = IDX_W'(j);
            found  = 1'b1;
         end
      end
   end

   // Frees win the slot unless they have starved a pending alloc for too long
   always_comb begin
      cand    = alloc_en && found;
      fifo_ne = rst_n && (fifo_cnt != '0);
      op      = OP_NONE;
      if (fifo_ne && (!cand || alloc_full || free_streak < STK_W'(STARVE_LIMIT))) op = OP_FREE;
      else if (cand) op = OP_ALLOC;
      alloc_req     = (op == OP_ALLOC);
      alloc_orig_id = alloc_req ? req_orig_id[winner] : '0;
      grant         = alloc_req && alloc_gnt;
      req_ready     = '0;
      if (grant) req_ready[winner] = 1'b1;
      free_req = (op == OP_FREE);
      free_uid = free_req ? fifo_head : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr          <= '0;
         out_cnt         <= '0;
         free_streak     <= '0;
         err_underflow   <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_req_idx     <= '0;
         rsp_unique_id   <= '0;
         restored_valid  <= 1'b0;
         restored_id_out <= '0;
      end else begin
         rsp_valid      <= grant;
         restored_valid <= free_req;
         if (grant) begin
            rsp_req_idx   <= winner;
            rsp_unique_id <= alloc_unique_id;
            rr_ptr        <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
            if (out_cnt != CNT_W'(MAX_OUTSTANDING)) out_cnt <= out_cnt + 1'b1;
         end
         if (free_req) begin
            restored_id_out <= alloc_restored_id;
            if (out_cnt == '0) err_underflow <= 1'b1;
            else               out_cnt       <= out_cnt - 1'b1;
         end
         if (free_req && cand) begin
            if (free_streak != STK_W'(STARVE_LIMIT)) free_streak <= free_streak + 1'b1;
         end else begin
            free_streak <= '0;
         end
      end
   end

endmodule

// File: tb/tb_id_alloc_scheduler.sv
// Randomized scoreboard bench for id_alloc_scheduler with a behavioural allocator and slot model.
module tb_id_alloc_scheduler;
   import rob_pkg::*;

   localparam int N = 4, W = 16, MAX = 16, DEPTH = 4, LIMIT = 4;
   localparam int IW = DEF_REQ_IDX_W;
   localparam int UB = $clog2(MAX);

   logic clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0]        req_valid;
   logic [N-1:0][W-1:0] req_orig_id;
   logic [N-1:0]        req_ready;
   logic                rsp_valid;
   logic [IW-1:0]       rsp_req_idx;
   logic [W-1:0]        rsp_unique_id;
   logic                free_valid;
   logic [W-1:0]        free_unique_id;
   logic                free_ready, restored_valid;
   logic [W-1:0]        restored_id_out;
   logic                drain_req, drain_done, err_underflow;
   logic                alloc_req, alloc_gnt, alloc_full, free_req;
   logic [W-1:0]        alloc_orig_id, alloc_unique_id, free_uid, alloc_restored_id;

   id_alloc_scheduler #(.NUM_REQ(N), .ID_WIDTH(W), .MAX_OUTSTANDING(MAX),
                        .FREE_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_orig_id(req_orig_id),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_req_idx(rsp_req_idx),
      .rsp_unique_id(rsp_unique_id), .free_valid(free_valid), .free_unique_id(free_unique_id),
      .free_ready(free_ready), .restored_valid(restored_valid), .restored_id_out(restored_id_out),
      .drain_req(drain_req), .drain_done(drain_done), .err_underflow(err_underflow),
      .alloc_req(alloc_req), .alloc_orig_id(alloc_orig_id), .alloc_gnt(alloc_gnt),
      .alloc_unique_id(alloc_unique_id), .alloc_full(alloc_full), .free_req(free_req),
      .free_uid(free_uid), .alloc_restored_id(alloc_restored_id)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0;
   bit armed = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Environment: allocator with lowest-free-ID policy
   bit           used [MAX];
   bit [W-1:0]   tbl  [MAX];
   int           used_cnt = 0;
   bit           force_full = 0;

   always_comb begin
      alloc_unique_id = '0;
      for (int i = MAX - 1; i >= 0; i--) if (!used[i]) alloc_unique_id = W'(i);
      alloc_full        = force_full || (used_cnt == MAX);
      alloc_gnt         = alloc_req && !alloc_full;
      alloc_restored_id = tbl[free_uid[UB-1:0]];
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX; i++) used[i] <= 1'b0;
         used_cnt <= 0;
      end else begin
         if (alloc_req && alloc_gnt) begin
            used[alloc_unique_id[UB-1:0]] <= 1'b1;
            tbl[alloc_unique_id[UB-1:0]]  <= alloc_orig_id;
            used_cnt <= used_cnt + 1;
         end else if (free_req && used[free_uid[UB-1:0]]) begin
            used[free_uid[UB-1:0]] <= 1'b0;
            used_cnt <= used_cnt - 1;
         end
      end
   end

   // Reference model: pending frees as a queue, counters as plain integers
   typedef struct {int cyc; int idx; logic [W-1:0] val;} exp_t;
   exp_t         rsp_q[$], rst_q[$];
   logic [W-1:0] m_fifo[$];
   logic [W-1:0] live[$];
   logic [W-1:0] orig_of[int];
   int           m_rr = 0, m_out = 0, m_streak = 0, m_mode = 0;
   bit           m_err = 0;

   always @(negedge clk) begin : model
      bit cand, grant, push_ok, found;
      int win, op, nm, j, u;
      if (!rst_n) begin
         chk("rst_alloc_req", alloc_req, 0);
         chk("rst_free_req", free_req, 0);
         chk("rst_req_ready", req_ready, 0);
         m_rr = 0; m_out = 0; m_streak = 0; m_mode = 0; m_err = 0;
         m_fifo.delete();
      end else begin
         cand = (m_mode == 0) && (req_valid != '0);
         win = 0; found = 0;
         for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (!found && req_valid[j]) begin win = j; found = 1; end
         end
         if (m_fifo.size() > 0 && (!cand || alloc_full || m_streak < LIMIT)) op = 2;
         else if (cand) op = 1;
         else op = 0;
         grant = (op == 1) && !alloc_full;
         chk("alloc_req", alloc_req, op == 1);
         chk("free_req", free_req, op == 2);
         chk("req_ready", req_ready, grant ? (64'd1 << win) : 64'd0);
         chk("free_ready", free_ready, m_fifo.size() < DEPTH);
         chk("drain_done", drain_done, m_mode == 2);
         chk("err_underflow", err_underflow, m_err);
         if (op == 1) chk("alloc_orig_id", alloc_orig_id, req_orig_id[win]);
         if (op == 2) chk("free_uid", free_uid, m_fifo[0]);
         nm = m_mode;
         if (m_mode == 0 && drain_req) nm = 1;
         else if (m_mode == 1 && m_out == 0 && m_fifo.size() == 0) nm = 2;
         else if (m_mode == 2 && !drain_req) nm = 0;
         push_ok = free_valid && (m_fifo.size() < DEPTH);
         if (grant) begin
            rsp_q.push_back('{cyc, win, alloc_unique_id});
            orig_of[int'(alloc_unique_id)] = req_orig_id[win];
            m_rr = (win + 1) % N;
            if (m_out < MAX) m_out++;
         end
         if (op == 2) begin
            u = int'(m_fifo.pop_front());
            rst_q.push_back('{cyc, 0, orig_of.exists(u) ? orig_of[u] : '0});
            if (m_out == 0) m_err = 1;
            else m_out--;
         end
         m_streak = (op == 2 && cand) ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
         if (push_ok) m_fifo.push_back(free_unique_id);
         m_mode = nm;
      end
   end

   always @(negedge clk) begin : monitor
      bit   due;
      exp_t e;
      if (armed) begin
         due = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc - 1);
         chk("rsp_valid", rsp_valid, due);
         if (due) begin
            e = rsp_q.pop_front();
            if (rsp_valid) begin
               chk("rsp_req_idx", rsp_req_idx, e.idx);
               chk("rsp_unique_id", rsp_unique_id, e.val);
            end
            live.push_back(e.val);
         end
         due = (rst_q.size() > 0) && (rst_q[0].cyc == cyc - 1);
         chk("restored_valid", restored_valid, due);
         if (due) begin
            e = rst_q.pop_front();
            if (restored_valid) chk("restored_id_out", restored_id_out, e.val);
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         total++;
         assert (!(alloc_req && free_req))
         else begin bad++; $display("FAIL excl_op: alloc_req and free_req both high (cycle %0d)", cyc); end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = '0; free_valid = 0; drain_req = 0; force_full = 0;
   endtask

   task automatic push_free(input logic [W-1:0] uid);
      free_valid = 1; free_unique_id = uid;
      tick();
      free_valid = 0;
   endtask

   task automatic check_reset_vals();
      chk("rv_rsp_valid", rsp_valid, 0);
      chk("rv_rsp_req_idx", rsp_req_idx, 0);
      chk("rv_rsp_unique_id", rsp_unique_id, 0);
      chk("rv_restored_valid", restored_valid, 0);
      chk("rv_restored_id_out", restored_id_out, 0);
      chk("rv_drain_done", drain_done, 0);
      chk("rv_err_underflow", err_underflow, 0);
      chk("rv_free_ready", free_ready, 1);
      chk("rv_req_ready", req_ready, 0);
      chk("rv_alloc_req", alloc_req, 0);
      chk("rv_free_req", free_req, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int guard, idx, drain_left;
      idle();
      req_orig_id = '0; free_unique_id = '0;
      rst_n = 0;
      repeat (2) tick();
      rst_n = 1;
      #1;
      check_reset_vals();
      armed = 1;

      // all four requesting, allocator always grants
      req_orig_id[0] = 16'hA; req_orig_id[1] = 16'hB;
      req_orig_id[2] = 16'hC; req_orig_id[3] = 16'hD;
      req_valid = 4'b1111;
      repeat (8) tick();
      req_valid = '0;
      tick();

      // allocator full: request visible but never granted
      force_full = 1; req_valid = 4'b0001;
      repeat (3) tick();
      idle();
      tick();

      // back-to-back frees against pending allocs
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) push_free(live.pop_front());
      repeat (10) tick();
      idle();
      repeat (6) tick();

      // free and alloc arriving together into an empty FIFO
      req_valid = 4'b0010;
      if (live.size() > 0) push_free(live.pop_front());
      else tick();
      idle();
      repeat (3) tick();

      // randomized traffic
      drain_left = 0;
      for (int c = 0; c < 400; c++) begin
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++) req_orig_id[i] = W'($urandom);
         force_full = ($urandom_range(0, 9) == 0);
         if (drain_left > 0) begin drain_left--; drain_req = 1; end
         else begin
            drain_req = 0;
            if ($urandom_range(0, 79) == 0) drain_left = $urandom_range(10, 40);
         end
         if (live.size() > 0 && free_ready && $urandom_range(0, 2) != 0) begin
            idx = $urandom_range(0, live.size() - 1);
            free_valid = 1; free_unique_id = live[idx];
            live.delete(idx);
         end else begin
            free_valid = 0;
         end
         tick();
      end
      idle();

      // drain with requesters still asking
      req_valid = 4'b1111;
      repeat (4) tick();
      drain_req = 1;
      repeat (2) tick();
      guard = 0;
      while (!drain_done && guard < 200) begin
         if (live.size() > 0 && free_ready) begin
            free_valid = 1; free_unique_id = live.pop_front();
         end else begin
            free_valid = 0;
         end
         tick();
         guard++;
      end
      free_valid = 0;
      chk("drain_reached", drain_done, 1);
      drain_req = 0;
      repeat (2) tick();
      chk("drain_exit", drain_done, 0);
      req_valid = '0;
      repeat (3) tick();
      while (live.size() > 0) push_free(live.pop_front());
      repeat (4) tick();

      // free with nothing outstanding
      push_free(16'd5);
      repeat (2) tick();
      chk("underflow_sticky", err_underflow, 1);
      repeat (3) tick();
      chk("underflow_still", err_underflow, 1);

      // reset in the middle of a burst
      req_valid = 4'b1111;
      repeat (3) tick();
      if (live.size() > 0) begin free_valid = 1; free_unique_id = live.pop_front(); end
      tick();
      rst_n = 0;
      free_valid = 0;
      tick();
      rst_n = 1;
      idle();
      live.delete();
      #1;
      check_reset_vals();
      repeat (4) tick();

      chk("rsp_q_empty", rsp_q.size(), 0);
      chk("rst_q_empty", rst_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
